smol_wb_queue: RTL
==================

SMOL_WB_QUEUE -- requirements
Module: smol_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port inValid  input  1  producer offers a result.
REQ-006 Port inReady  output  1  queue accepts a result this cycle.
REQ-007 Port inAddr  input  5  destination register index.
REQ-008 Port inData  input  XLEN  result value.
REQ-009 Port wStall  input  1  register-file write port is taken by a higher-priority writer this cycle.
REQ-010 Port flush  input  1  discard all pending entries.
REQ-011 Port wEnable  output  1  register-file write strobe.
REQ-012 Port wAddr  output  5  register-file write index.
REQ-013 Port wData  output  XLEN  register-file write value.
REQ-014 Port lkAddr1, lkAddr2  input  5 each  forwarding lookup indices.
REQ-015 Port lkHit1, lkHit2  output  1 each  lookup matched a pending entry.
REQ-016 Port lkData1, lkData2  output  XLEN each  forwarded value.
REQ-017 Port count  output  $clog2(DEPTH)+1  number of pending entries.

Function
REQ-018 Accept when inValid && inReady; the entry is appended at the tail and is visible to lookups and count from the next cycle.
REQ-019 inReady = rst && !flush && (count < DEPTH || drain this cycle).
REQ-020 inAddr == 0 accepted: handshake completes, nothing enqueued, count unchanged.
REQ-021 drain = (count != 0) && !wStall && !flush; when drain, wEnable=1 with wAddr/wData = head entry (combinational from state); head pops at the edge.
REQ-022 When !drain, wEnable=0, wAddr=0, wData=0.
REQ-023 Minimum latency accept-to-wEnable is one cycle; strict FIFO order; at most one write per cycle.
REQ-024 Full and draining: accept and pop in the same cycle; count unchanged.
REQ-025 Empty: no bypass from inData to the write port; an entry is never written in its acceptance cycle.
REQ-026 Read and write pointers wrap modulo DEPTH; count distinguishes full from empty.
REQ-027 Lookup: lkHitN=1 iff lkAddrN != 0 and some pending entry has that index; lkDataN = data of the youngest match; else lkHitN=0, lkDataN=0.
REQ-028 The head entry being drained this cycle still counts for lookups in that cycle.
REQ-029 Lookups are combinational and ignore same-cycle inValid.
REQ-030 flush: the next cycle has count=0; no write and no accept in the flush cycle; flush overrides wStall and inValid.

Reset
REQ-031 While rst=0 at an edge: pointers and count cleared; the cycle after shows count=0, wEnable=0, wAddr=0, wData=0, lkHit=0, lkData=0.
REQ-032 While rst=0: inReady=0 and wEnable=0 combinationally; reset mid-operation drops all pending entries with no register-file write.
REQ-033 Entry data storage needs no reset; only pointers, count and valid state are reset.

Structure
REQ-034 Shared package smol_pkg holds XLEN, REG_AW=5, the register-index typedef and the wb_entry_t struct {addr, data}.
REQ-035 One sub-module, smol_wb_lookup (youngest-match priority search over the entries), instantiated once per lookup port.
REQ-036 Entries live in one array indexed by the pointers; no shift register.

Verification
REQ-037 Reset, accept x5=0xDEADBEEF at cycle 1 -> cycle 2 wEnable=1, wAddr=5, wData=0xDEADBEEF; cycle 3 count=0.
REQ-038 wStall held, 4 accepts (x1..x4 = 0x11..0x44) -> count=4, inReady=0; on the 5th offer release wStall -> the 5th is accepted the same cycle, writes come out x1,x2,x3,x4 then x5 in order.
REQ-039 Pending x7=0x1 then x7=0x2 (wStall=1), lkAddr1=7 -> lkHit1=1, lkData1=0x2; lkAddr2=0 -> lkHit2=0.
REQ-040 Accept x0=0xFFFF_FFFF -> inReady=1 on the handshake, count stays 0, no wEnable in the following cycles.
REQ-041 3 pending entries, flush=1 together with inValid=1 -> inReady=0 and wEnable=0 that cycle; next cycle count=0 and lkHit=0.
REQ-042 2 pending entries, rst=0 for one cycle -> no write that cycle; afterwards count=0 and inReady=1.

Source files
------------

// File: rtl/smol_pkg.sv
// Shared types for the writeback queue.
// Register index and queued writeback entry.
package smol_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          addr;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/smol_wb_lookup.sv
// Youngest-match forwarding search over the pending entries.
// Walks oldest to youngest so the last hit wins.
module smol_wb_lookup
    import smol_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  reg_idx_t         addrs_i [DEPTH],
    input  logic [DW-1:0]    datas_i [DEPTH],
    input  logic [PW-1:0]    head_i,
    input  logic [CW-1:0]    count_i,
    input  reg_idx_t         addr_i,
    output logic             hit_o,
    output logic [DW-1:0]    data_o
);
    logic [PW-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (CW'(k) < count_i && addr_i != '0 &&
                addrs_i[idx] == addr_i) begin
                hit_o  = 1'b1;
                data_o = datas_i[idx];
            end
        end
    end
endmodule

// File: rtl/smol_wb_queue.sv
// Writeback queue: circular buffer draining into one register-file
// write port, with two forwarding lookup ports.
module smol_wb_queue
    import smol_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = smol_pkg::XLEN,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    output logic            inReady,
    input  reg_idx_t        inAddr,
    input  logic [XLEN-1:0] inData,
    input  logic            wStall,
    input  logic            flush,
    output logic            wEnable,
    output reg_idx_t        wAddr,
    output logic [XLEN-1:0] wData,
    input  reg_idx_t        lkAddr1,
    input  reg_idx_t        lkAddr2,
    output logic            lkHit1,
    output logic            lkHit2,
    output logic [XLEN-1:0] lkData1,
    output logic [XLEN-1:0] lkData2,
    output logic [CW-1:0]   count
);
    reg_idx_t        addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   rp_q, rp_d;
    logic [PW-1:0]   wp_q, wp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drain;
    logic            push;

    assign drain   = rst && (cnt_q != '0) && !wStall && !flush;
    assign inReady = rst && !flush &&
                     ((cnt_q < CW'(DEPTH)) || drain);
    // x0 completes the handshake but is never stored.
    assign push    = inValid && inReady && (inAddr != '0);

    assign wEnable = drain;
    assign wAddr   = drain ? addr_q[rp_q] : '0;
    assign wData   = drain ? data_q[rp_q] : '0;
    assign count   = cnt_q;

    always_comb begin
        rp_d  = rp_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (flush) begin
            rp_d  = '0;
            wp_d  = '0;
            cnt_d = '0;
        end else begin
            if (drain) rp_d = rp_q + 1'b1;
            if (push)  wp_d = wp_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wp_q] <= inAddr;
            data_q[wp_q] <= inData;
        end
    end

    smol_wb_lookup #(.DEPTH(DEPTH), .DW(XLEN)) u_lk1 (
        .addrs_i (addr_q),
        .datas_i (data_q),
        .head_i  (rp_q),
        .count_i (cnt_q),
        .addr_i  (lkAddr1),
        .hit_o   (lkHit1),
        .data_o  (lkData1)
    );

    smol_wb_lookup #(.DEPTH(DEPTH), .DW(XLEN)) u_lk2 (
        .addrs_i (addr_q),
        .datas_i (data_q),
        .head_i  (rp_q),
        .count_i (cnt_q),
        .addr_i  (lkAddr2),
        .hit_o   (lkHit2),
        .data_o  (lkData2)
    );
endmodule
